// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO types and write-arbiter state encoding
package fifo_pkg;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 16;

    typedef logic [DATA_W-1:0] data_ty;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        HOLD  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - round-robin pick of the first set request at or after rr_ptr
module rr_priority_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] rr_ptr,
    output logic [$clog2(N_REQ)-1:0] idx,
    output logic                     valid
);

    localparam int IDX_W = $clog2(N_REQ);

    // Scan from the far end back toward rr_ptr so the closest requester is written last.
    always_comb begin
        int j;
        j     = 0;
        valid = 1'b0;
        idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = int'(rr_ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (req[IDX_W'(j)]) begin
                valid = 1'b1;
                idx   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for the fifo_top write port
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  data_ty                   data_in [N_REQ],
    input  logic                     fifo_full,
    output logic [N_REQ-1:0]         grant,
    output logic                     fifo_push,
    output data_ty                   fifo_data,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     busy,
    output logic [CNT_W-1:0]         push_cnt
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int BC_W  = $clog2(MAX_BURST) + 1;

    arb_state_e         state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [BC_W-1:0]    burst_cnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic [IDX_W-1:0]   next_owner;
    logic               last_word;

    rr_priority_pick #(.N_REQ(N_REQ)) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    assign next_owner = (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
    assign last_word  = (burst_cnt == BC_W'(MAX_BURST - 1));
    assign busy       = (state != IDLE);

    // Grant is gated by rst so a reset landing mid-burst never pushes in its own cycle.
    always_comb begin
        grant = '0;
        if (rst && state == BURST && req[owner] && !fifo_full)
            grant[owner] = 1'b1;
        fifo_push = |(grant & req);
        fifo_data = fifo_push ? data_in[owner] : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            burst_cnt <= '0;
            push_cnt  <= '0;
        end else begin
            if (fifo_push)
                push_cnt <= push_cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (pick_valid && !fifo_full) begin
                        owner     <= pick_idx;
                        burst_cnt <= '0;
                        state     <= BURST;
                    end
                end
                BURST: begin
                    if (fifo_push)
                        burst_cnt <= burst_cnt + 1'b1;
                    // A final word accepted as full rises still ends the burst rather than holding.
                    if (!req[owner] || (fifo_push && last_word)) begin
                        state  <= IDLE;
                        rr_ptr <= next_owner;
                    end else if (fifo_full) begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (!req[owner]) begin
                        state  <= IDLE;
                        rr_ptr <= next_owner;
                    end else if (!fifo_full) begin
                        state <= BURST;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - randomized self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
    import fifo_pkg::*;

    localparam int N  = 4;
    localparam int MB = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    data_ty        data_in [N];
    logic          fifo_full;
    logic [N-1:0]  grant;
    logic          fifo_push;
    data_ty        fifo_data;
    logic [1:0]    owner;
    logic          busy;
    logic [CW-1:0] push_cnt;

    fifo_wr_arbiter #(.N_REQ(N), .MAX_BURST(MB), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in), .fifo_full(fifo_full),
        .grant(grant), .fifo_push(fifo_push), .fifo_data(fifo_data), .owner(owner),
        .busy(busy), .push_cnt(push_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Abstract model: who holds the port, how many words it has used, whether it is stalled.
    bit m_busy, m_stall;
    int m_owner, m_ptr, m_used, m_cnt;

    data_ty fifo_q[$];
    data_ty gold_q[$];
    bit     pop_en;
    bit     last_push;
    int     last_owner;

    task automatic tick();
        logic [N-1:0] r, exp_grant;
        logic         f, rs, exp_push;
        data_ty       exp_data, got;
        @(negedge clk);
        r = req; f = fifo_full; rs = rst;
        exp_push  = rs && m_busy && !m_stall && r[m_owner] && !f;
        exp_grant = exp_push ? (N'(1) << m_owner) : '0;
        exp_data  = exp_push ? data_in[m_owner] : '0;
        checks++; if (grant !== exp_grant) begin errors++; $display("FAIL grant: got %b expected %b at %0t", grant, exp_grant, $time); end
        checks++; if (fifo_push !== exp_push) begin errors++; $display("FAIL fifo_push: got %b expected %b at %0t", fifo_push, exp_push, $time); end
        checks++; if (fifo_data !== exp_data) begin errors++; $display("FAIL fifo_data: got %h expected %h at %0t", fifo_data, exp_data, $time); end
        checks++; if (owner !== 2'(m_owner)) begin errors++; $display("FAIL owner: got %0d expected %0d at %0t", owner, m_owner, $time); end
        checks++; if (busy !== m_busy) begin errors++; $display("FAIL busy: got %b expected %b at %0t", busy, m_busy, $time); end
        checks++; if (push_cnt !== CW'(m_cnt)) begin errors++; $display("FAIL push_cnt: got %0d expected %0d at %0t", push_cnt, m_cnt, $time); end
        last_push  = exp_push;
        last_owner = m_owner;
        if (fifo_push === 1'b1) fifo_q.push_back(fifo_data);
        if (exp_push) gold_q.push_back(exp_data);
        @(posedge clk);
        if (!rs) begin
            m_busy = 0; m_stall = 0; m_ptr = 0; m_owner = 0; m_used = 0; m_cnt = 0;
        end else if (!m_busy) begin
            if (r != 0 && !f) begin
                for (int k = N - 1; k >= 0; k--)
                    if (r[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
                m_busy = 1; m_stall = 0; m_used = 0;
            end
        end else if (!r[m_owner]) begin
            m_busy = 0; m_ptr = (m_owner + 1) % N;
        end else if (m_stall) begin
            if (!f) m_stall = 0;
        end else if (!f) begin
            m_used++; m_cnt = (m_cnt + 1) % (1 << CW);
            if (m_used == MB) begin m_busy = 0; m_ptr = (m_owner + 1) % N; end
        end else begin
            m_stall = 1;
        end
        if (pop_en && fifo_q.size() > 0) begin
            got = fifo_q.pop_front();
            checks++;
            if (gold_q.size() == 0) begin errors++; $display("FAIL fifo_order: got %h expected nothing", got); end
            else begin
                exp_data = gold_q.pop_front();
                if (got !== exp_data) begin errors++; $display("FAIL fifo_order: got %h expected %h", got, exp_data); end
            end
        end
        #1;
        fifo_full = (fifo_q.size() >= FIFO_DEPTH);
        for (int i = 0; i < N; i++) data_in[i] = data_ty'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b0; req = '0; pop_en = 0;
        tick(); tick();
        rst = 1'b1;
        fifo_q.delete(); gold_q.delete();
        fifo_full = 1'b0;
    endtask

    task automatic preload(int n);
        data_ty d;
        for (int i = 0; i < n; i++) begin
            d = data_ty'($urandom);
            fifo_q.push_back(d); gold_q.push_back(d);
        end
    endtask

    task automatic fill_until_full(string name);
        int cyc = 0;
        while (!fifo_full && cyc < 80) begin tick(); cyc++; end
        checks++; if (!fifo_full) begin errors++; $display("FAIL %s_fill: fifo_full=%b expected 1", name, fifo_full); end
    endtask

    task automatic test_reset();
        rst = 1'b0; req = '1; pop_en = 0;
        tick(); tick();
        checks++; if (grant !== '0 || fifo_push !== 1'b0 || fifo_data !== '0) begin
            errors++; $display("FAIL reset_outputs: grant=%b push=%b data=%h expected 0", grant, fifo_push, fifo_data); end
        checks++; if (busy !== 1'b0 || owner !== 2'd0 || push_cnt !== '0) begin
            errors++; $display("FAIL reset_state: busy=%b owner=%0d push_cnt=%0d expected 0", busy, owner, push_cnt); end
        do_reset();
    endtask

    task automatic test_single();
        int idx[$];
        int cyc = 0;
        do_reset();
        req = 4'b0001; pop_en = 1;
        while (idx.size() < 6 && cyc < 40) begin tick(); if (last_push) idx.push_back(cyc); cyc++; end
        req = '0;
        tick();
        checks++; if (idx.size() != 6) begin errors++; $display("FAIL single_count: got %0d pushes expected 6", idx.size()); end
        else begin
            checks++; if (idx[3] - idx[0] != 3 || idx[4] - idx[3] != 2 || idx[5] - idx[4] != 1) begin
                errors++; $display("FAIL single_gap: push cycles %0d %0d %0d %0d %0d %0d expected 4 back-to-back, 1 idle, 2",
                                   idx[0], idx[1], idx[2], idx[3], idx[4], idx[5]); end
        end
        checks++; if (push_cnt !== CW'(6)) begin errors++; $display("FAIL single_push_cnt: got %0d expected 6", push_cnt); end
    endtask

    task automatic test_fairness();
        int n = 0, cyc = 0;
        do_reset();
        req = 4'b1111; pop_en = 1;
        while (n < 20 && cyc < 60) begin
            tick(); cyc++;
            if (last_push) begin
                checks++; if (last_owner != (n / MB) % N) begin
                    errors++; $display("FAIL fair_order: word %0d from %0d expected %0d", n, last_owner, (n / MB) % N); end
                n++;
            end
        end
        checks++; if (n != 20) begin errors++; $display("FAIL fair_count: got %0d expected 20", n); end
        req = '0; tick();
    endtask

    task automatic test_full();
        int n = 0;
        do_reset();
        preload(2);
        req = 4'b0001; pop_en = 0;
        fill_until_full("full");
        tick(); tick();
        checks++; if (busy !== 1'b1 || grant !== '0 || fifo_push !== 1'b0) begin
            errors++; $display("FAIL full_hold: busy=%b grant=%b push=%b expected 1,0,0", busy, grant, fifo_push); end
        pop_en = 1; tick(); pop_en = 0;
        for (int i = 0; i < 6; i++) begin tick(); if (last_push) n++; end
        checks++; if (n != 1) begin errors++; $display("FAIL full_one_word: got %0d pushes expected 1", n); end
        req = '0; pop_en = 1;
        for (int i = 0; i < 20; i++) tick();
        checks++; if (fifo_q.size() != 0 || gold_q.size() != 0) begin
            errors++; $display("FAIL full_drain: fifo %0d golden %0d entries left expected 0", fifo_q.size(), gold_q.size()); end
    endtask

    task automatic test_drop_hold();
        int cyc = 0;
        do_reset();
        preload(2);
        req = 4'b0100; pop_en = 0;
        fill_until_full("drop");
        tick(); tick();
        req = '0; tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_idle: busy=%b expected 0", busy); end
        req = 4'b1111; pop_en = 1;
        while (!busy && cyc < 10) begin tick(); cyc++; end
        checks++; if (busy !== 1'b1 || owner !== 2'd3) begin
            errors++; $display("FAIL drop_rotate: busy=%b owner=%0d expected 1,3", busy, owner); end
        req = '0;
        for (int i = 0; i < 20; i++) tick();
    endtask

    task automatic test_reset_mid();
        int n = 0, cyc = 0;
        do_reset();
        req = 4'b1111; pop_en = 1;
        while (n < 2 && cyc < 20) begin tick(); if (last_push) n++; cyc++; end
        rst = 1'b0; tick(); rst = 1'b1;
        checks++; if (grant !== '0 || push_cnt !== '0 || busy !== 1'b0 || owner !== 2'd0) begin
            errors++; $display("FAIL reset_mid: grant=%b push_cnt=%0d busy=%b owner=%0d expected 0", grant, push_cnt, busy, owner); end
        tick();
        req = '0;
        for (int i = 0; i < 20; i++) tick();
    endtask

    task automatic test_wrap();
        int n = 0, cyc = 0;
        do_reset();
        req = N'($urandom_range(1, (1 << N) - 1)); pop_en = 1;
        while (n < 17 && cyc < 100) begin tick(); if (last_push) n++; cyc++; end
        req = '0; tick();
        checks++; if (push_cnt !== CW'(1)) begin errors++; $display("FAIL wrap: push_cnt=%0d expected 1 after %0d pushes", push_cnt, n); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) req = N'($urandom);
            pop_en = ($urandom_range(0, 2) != 0);
            tick();
        end
        req = '0; pop_en = 1;
        for (int i = 0; i < 20; i++) tick();
        checks++; if (fifo_q.size() != gold_q.size()) begin
            errors++; $display("FAIL random_drain: fifo %0d golden %0d entries", fifo_q.size(), gold_q.size()); end
    endtask

    initial begin
        rst = 1'b0; req = '0; fifo_full = 1'b0; pop_en = 0;
        m_busy = 0; m_stall = 0; m_owner = 0; m_ptr = 0; m_used = 0; m_cnt = 0;
        for (int i = 0; i < N; i++) data_in[i] = data_ty'($urandom);
        test_reset();
        test_single();
        test_fairness();
        test_full();
        test_drop_hold();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
